// File: rtl/sequential_unsigned_divider_32.sv
// ---------------------------------------------------------------------------
// sequential_unsigned_divider_32
//
// Iterative radix-2 restoring unsigned divider. It retires one quotient bit
// per clock, MSB first. A WIDTH-bit division takes WIDTH RUN cycles plus one
// DONE cycle. A zero divisor skips RUN and produces quotient = all ones,
// remainder = dividend and div_by_zero = 1.
//
// The result registers load on the edge that leaves DONE, and done pulses
// for one cycle at the same time. done is therefore high in the first IDLE
// cycle after the operation.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over start)
//   start        request a division; sampled only in IDLE
//   A            dividend, captured on the accepted start
//   B            divisor, captured on the accepted start
//   quotient     registered quotient, held until the next result
//   remainder    registered remainder, held until the next result
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle pulse when quotient/remainder are updated
//   div_by_zero  high if the most recent result had a zero divisor
// ---------------------------------------------------------------------------
module sequential_unsigned_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  // Holds the dividend bits that remain. Quotient bits shift in at the LSB,
  // so after WIDTH steps this register holds the whole quotient.
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   part_rem;
  logic             work_dbz;

  logic             last_iter;
  logic             load_results;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_step;
  logic             fits;

  assign last_iter = (count == CW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, then subtract the
  // divisor if it fits. part_rem stays below the divisor between steps, so
  // its top bit is always clear. That bit is ORed into the compare only to
  // keep the arithmetic correct by construction.
  always_comb begin
    rem_shift = {part_rem[WIDTH-1:0], work_q[WIDTH-1]};
    fits      = part_rem[WIDTH] | (rem_shift >= {1'b0, divisor});
    rem_step  = fits ? (rem_shift - {1'b0, divisor}) : rem_shift;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (B == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy         = (state != IDLE);
    load_results = (state == DONE);
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      work_q      <= '0;
      divisor     <= '0;
      part_rem    <= '0;
      work_dbz    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= load_results;
      case (state)
        IDLE: begin
          if (start) begin
            divisor <= B;
            count   <= '0;
            if (B == '0) begin
              // A zero divisor goes straight to DONE with the result
              // already in the working registers.
              work_q   <= '1;
              part_rem <= {1'b0, A};
              work_dbz <= 1'b1;
            end else begin
              work_q   <= A;
              part_rem <= '0;
              work_dbz <= 1'b0;
            end
          end
        end
        RUN: begin
          part_rem <= rem_step;
          work_q   <= {work_q[WIDTH-2:0], fits};
          count    <= count + CW'(1);
        end
        DONE: begin
          quotient    <= work_q;
          remainder   <= part_rem[WIDTH-1:0];
          div_by_zero <= work_dbz;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
